// File: rtl/rocc_arb_pkg.sv
// Shared constants and helpers for the RoCC command arbiter.
// Pure declarations: no logic, no latency, no flow control.
package rocc_arb_pkg;

    localparam int CntWidth      = 32;
    localparam int RoccCmdWidth  = 128;
    localparam int RoccRespWidth = 69;

    // A single requester still needs one ID bit so the FIFO has a data path.
    function automatic int id_width(input int nr_req);
        return (nr_req > 1) ? $clog2(nr_req) : 1;
    endfunction

endpackage

// File: rtl/rocc_arb_id_fifo.sv
// Requester-ID FIFO: Depth x Width storage, head visible combinationally, 1-cycle push-to-head.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps occupancy.
module rocc_arb_id_fifo #(
    parameter int Depth = 4,
    parameter int Width = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [Width-1:0]         push_dat,
    input  logic                     pop,
    output logic [Width-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   usage
);
    localparam int PtrWidth = $clog2(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth:0]   cnt;
    logic                do_push;
    logic                do_pop;

    assign full     = (cnt == (PtrWidth+1)'(Depth));
    assign empty    = (cnt == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];
    assign usage    = cnt;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/rocc_arbiter.sv
// Round-robin share of one RoCC accelerator among NrReq sources; ROCC_ARB_PERF_CNT_EN adds grant counters.
// Zero-latency command/response paths; grant locks under accelerator backpressure, xd commands stall on a full ID FIFO.
module rocc_arbiter
    import rocc_arb_pkg::*;
#(
    parameter int NrReq          = 2,
    parameter int CmdWidth       = RoccCmdWidth,
    parameter int RespWidth      = RoccRespWidth,
    parameter int MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NrReq*CmdWidth-1:0]       req_cmd_i,
    input  logic [NrReq-1:0]                req_cmd_xd_i,
    input  logic [NrReq-1:0]                req_cmd_valid_i,
    output logic [NrReq-1:0]                req_cmd_ready_o,
    output logic [RespWidth-1:0]            req_resp_o,
    output logic [NrReq-1:0]                req_resp_valid_o,
    input  logic [NrReq-1:0]                req_resp_ready_i,
    output logic [CmdWidth-1:0]             acc_cmd_o,
    output logic                            acc_cmd_valid_o,
    input  logic                            acc_cmd_ready_i,
    input  logic [RespWidth-1:0]            acc_resp_i,
    input  logic                            acc_resp_valid_i,
    output logic                            acc_resp_ready_o,
    output logic [$clog2(MaxOutstanding):0] outstanding_o,
    output logic                            spurious_resp_o,
    output logic [NrReq*CntWidth-1:0]       grant_cnt_o
);
    localparam int IdWidth = id_width(NrReq);

    logic [IdWidth-1:0] rr_ptr;
    logic [IdWidth-1:0] rr_grant;
    logic [IdWidth-1:0] lock_idx;
    logic [IdWidth-1:0] grant;
    logic [IdWidth-1:0] grant_nxt;
    logic [IdWidth-1:0] head;
    logic               lock;
    logic               cmd_vld;
    logic               cmd_xd;
    logic               cmd_hs;
    logic               head_rdy;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    // Scan downwards so the first valid at or after rr_ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        rr_grant = rr_ptr;
        for (int i = NrReq - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NrReq;
            if (req_cmd_valid_i[idx]) rr_grant = IdWidth'(idx);
        end
    end

    assign grant = lock ? lock_idx : rr_grant;

    always_comb begin
        acc_cmd_o = '0;
        cmd_vld   = 1'b0;
        cmd_xd    = 1'b0;
        for (int k = 0; k < NrReq; k++) begin
            if (grant == IdWidth'(k)) begin
                acc_cmd_o = req_cmd_i[k*CmdWidth +: CmdWidth];
                cmd_vld   = req_cmd_valid_i[k];
                cmd_xd    = req_cmd_xd_i[k];
            end
        end
    end

    // Only commands that will produce a response need an ID slot.
    assign acc_cmd_valid_o = cmd_vld & ~(cmd_xd & fifo_full);
    assign cmd_hs          = acc_cmd_valid_o & acc_cmd_ready_i;
    assign fifo_push       = cmd_hs & cmd_xd;
    assign grant_nxt       = (grant == IdWidth'(NrReq - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_cmd_ready_o = '0;
        for (int k = 0; k < NrReq; k++) begin
            if (cmd_hs && grant == IdWidth'(k)) req_cmd_ready_o[k] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr          <= '0;
            lock            <= 1'b0;
            lock_idx        <= '0;
            spurious_resp_o <= 1'b0;
        end else begin
            if (cmd_hs) begin
                rr_ptr <= grant_nxt;
                lock   <= 1'b0;
            end else if (acc_cmd_valid_o) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
            if (acc_resp_valid_i && fifo_empty) spurious_resp_o <= 1'b1;
        end
    end

    rocc_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdWidth)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (fifo_push),
        .push_dat (grant),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .usage    (outstanding_o)
    );

    always_comb begin
        req_resp_valid_o = '0;
        head_rdy         = 1'b0;
        for (int k = 0; k < NrReq; k++) begin
            if (head == IdWidth'(k)) begin
                req_resp_valid_o[k] = acc_resp_valid_i & ~fifo_empty;
                head_rdy            = req_resp_ready_i[k];
            end
        end
    end

    // A response with no recorded owner is held back rather than dropped.
    assign req_resp_o       = acc_resp_i;
    assign acc_resp_ready_o = ~fifo_empty & head_rdy;
    assign fifo_pop         = acc_resp_valid_i & acc_resp_ready_o;

`ifdef ROCC_ARB_PERF_CNT_EN
    logic [CntWidth-1:0] cnt_q [NrReq];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NrReq; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NrReq; k++) begin
                if (cmd_hs && grant == IdWidth'(k) && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int k = 0; k < NrReq; k++) grant_cnt_o[k*CntWidth +: CntWidth] = cnt_q[k];
    end
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rocc_arbiter.sv
// Randomized bench for rocc_arbiter with a queue-based reference model and response scoreboard.
module tb_rocc_arbiter;
    localparam int NR = 2;
    localparam int CW = 128;
    localparam int RW = 69;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CW-1:0]   cmd_d [NR];
    logic [NR*CW-1:0] req_cmd;
    logic [NR-1:0]   xd, cvld, crdy, rvld, rrdy;
    logic [RW-1:0]   resp, acc_resp;
    logic [CW-1:0]   acc_cmd;
    logic            acc_cmd_vld, acc_cmd_rdy, acc_resp_vld, acc_resp_rdy, spurious;
    logic [2:0]      outstanding;
    logic [NR*32-1:0] grant_cnt;

    assign req_cmd = {cmd_d[1], cmd_d[0]};

    always #5 clk = ~clk;

    rocc_arbiter #(
        .NrReq(NR), .CmdWidth(CW), .RespWidth(RW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_cmd_i(req_cmd), .req_cmd_xd_i(xd), .req_cmd_valid_i(cvld), .req_cmd_ready_o(crdy),
        .req_resp_o(resp), .req_resp_valid_o(rvld), .req_resp_ready_i(rrdy),
        .acc_cmd_o(acc_cmd), .acc_cmd_valid_o(acc_cmd_vld), .acc_cmd_ready_i(acc_cmd_rdy),
        .acc_resp_i(acc_resp), .acc_resp_valid_i(acc_resp_vld), .acc_resp_ready_o(acc_resp_rdy),
        .outstanding_o(outstanding), .spurious_resp_o(spurious), .grant_cnt_o(grant_cnt)
    );

    typedef struct {
        int          id;
        logic [RW-1:0] dat;
    } exp_t;

    // Reference model: rotating priority, pending owner list, sticky error, grant tallies.
    int            m_ptr;
    int            m_lock;
    int            m_ids[$];
    bit            m_spur;
    logic [31:0]   m_cnt [NR];
    exp_t          sb_q[$];
    logic [RW-1:0] acc_todo[$];
    bit            resp_en;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_lock = -1;
        m_ids.delete();
        sb_q.delete();
        acc_todo.delete();
        m_spur = 1'b0;
        for (int k = 0; k < NR; k++) m_cnt[k] = '0;
    endtask

    task automatic new_cmd(input int k, input bit x);
        cmd_d[k] = {$urandom, $urandom, $urandom, $urandom};
        xd[k]    = x;
        cvld[k]  = 1'b1;
    endtask

    task automatic drive_resp();
        if (resp_en && !acc_resp_vld && acc_todo.size() > 0 && $urandom_range(0, 1) == 1) begin
            acc_resp     = acc_todo[0];
            acc_resp_vld = 1'b1;
        end
        rrdy = NR'($urandom);
    endtask

    // One clock: check at negedge against the model, advance the model, retire handshaken inputs.
    task automatic step();
        int            g;
        bit            exp_cv, hs, exp_rr, rhs;
        logic [NR-1:0] exp_cr, exp_rv;
        logic [31:0]   exp_gc;
        exp_t          e;
        @(negedge clk);
        g = m_ptr;
        if (m_lock >= 0) g = m_lock;
        else for (int i = NR - 1; i >= 0; i--) if (cvld[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
        exp_cv = cvld[g] && !(xd[g] && m_ids.size() == MO);
        chk("acc_cmd_valid", 128'(acc_cmd_vld), 128'(exp_cv));
        if (exp_cv) chk("acc_cmd_data", acc_cmd, cmd_d[g]);
        hs = exp_cv && acc_cmd_rdy;
        exp_cr = '0;
        if (hs) exp_cr[g] = 1'b1;
        chk("cmd_ready", 128'(crdy), 128'(exp_cr));
        chk("outstanding", 128'(outstanding), 128'(m_ids.size()));
        exp_rv = '0;
        exp_rr = 1'b0;
        if (m_ids.size() > 0) begin
            exp_rr = rrdy[m_ids[0]];
            if (acc_resp_vld) exp_rv[m_ids[0]] = 1'b1;
        end
        chk("resp_valid", 128'(rvld), 128'(exp_rv));
        chk("acc_resp_ready", 128'(acc_resp_rdy), 128'(exp_rr));
        chk("spurious", 128'(spurious), 128'(m_spur));
        for (int k = 0; k < NR; k++) begin
`ifdef ROCC_ARB_PERF_CNT_EN
            exp_gc = m_cnt[k];
`else
            exp_gc = '0;
`endif
            chk("grant_cnt", 128'(grant_cnt[k*32 +: 32]), 128'(exp_gc));
        end
        rhs = acc_resp_vld && exp_rr;
        if (acc_resp_vld && m_ids.size() == 0) m_spur = 1'b1;
        if (rhs) begin
            void'(m_ids.pop_front());
            void'(acc_todo.pop_front());
        end
        if (hs) begin
            m_ptr  = (g + 1) % NR;
            m_lock = -1;
            if (m_cnt[g] != 32'hFFFF_FFFF) m_cnt[g] = m_cnt[g] + 1;
            if (xd[g]) begin
                e.id  = g;
                e.dat = RW'({$urandom, $urandom, $urandom});
                m_ids.push_back(g);
                sb_q.push_back(e);
                acc_todo.push_back(e.dat);
            end
        end else if (exp_cv) begin
            m_lock = g;
        end
        @(posedge clk);
        #1;
        if (hs) cvld[g] = 1'b0;
        if (rhs) acc_resp_vld = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        cvld         = '0;
        acc_resp_vld = 1'b0;
        #1;
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_acc_cmd_valid", 128'(acc_cmd_vld), 128'(0));
        chk("rst_resp_valid", 128'(rvld), 128'(0));
        chk("rst_acc_resp_ready", 128'(acc_resp_rdy), 128'(0));
        chk("rst_spurious", 128'(spurious), 128'(0));
        chk("rst_grant_cnt", 128'(grant_cnt), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Response monitor: every delivered response must match the oldest expected one.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic [NR-1:0] oh;
        if (rst_n && ((rvld & rrdy) != '0)) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL resp_unexpected: got valid %b, no response pending", rvld);
            end else begin
                e = sb_q.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                chk("resp_route", 128'(rvld), 128'(oh));
                chk("resp_data", 128'(resp), 128'(e.dat));
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < NR; k++) cmd_d[k] = '0;
        cvld = '0; xd = '0; rrdy = '0;
        acc_cmd_rdy = 1'b0; acc_resp_vld = 1'b0; acc_resp = '0;
        resp_en = 1'b0;
        model_reset();
        #3;
        chk("reset_acc_cmd_valid", 128'(acc_cmd_vld), 128'(0));
        chk("reset_cmd_ready", 128'(crdy), 128'(0));
        chk("reset_resp_valid", 128'(rvld), 128'(0));
        chk("reset_acc_resp_ready", 128'(acc_resp_rdy), 128'(0));
        chk("reset_outstanding", 128'(outstanding), 128'(0));
        chk("reset_spurious", 128'(spurious), 128'(0));
        chk("reset_grant_cnt", 128'(grant_cnt), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Response with nothing outstanding: held, flagged, sticky until reset.
        acc_resp_vld = 1'b1;
        acc_resp     = RW'(69'h5);
        repeat (3) step();
        acc_resp_vld = 1'b0;
        step();
        chk("spurious_sticky", 128'(spurious), 128'(1));
        do_reset();

        // Backpressure lock: req0 stalls 3 cycles while req1 arrives.
        new_cmd(0, 1'b0);
        acc_cmd_rdy = 1'b0;
        step();
        new_cmd(1, 1'b1);
        step();
        step();
        acc_cmd_rdy = 1'b1;
        step();
        step();
        chk("lock_then_req1", 128'(outstanding), 128'(1));

        resp_en = 1'b1;
        guard = 0;
        while (acc_todo.size() != 0 && guard < 100) begin
            drive_resp();
            step();
            guard++;
        end
        chk("drain_after_lock", 128'(acc_todo.size()), 128'(0));
        resp_en = 1'b0;
        acc_resp_vld = 1'b0;
        rrdy = '0;

        // Fairness into full FIFO: four xd commands alternate, a fifth xd stalls, an xd=0 passes.
        for (int c = 0; c < MO; c++) begin
            for (int k = 0; k < NR; k++) if (!cvld[k]) new_cmd(k, 1'b1);
            step();
        end
        chk("full_occupancy", 128'(outstanding), 128'(MO));
        for (int k = 0; k < NR; k++) if (!cvld[k]) new_cmd(k, 1'b1);
        step();
        xd[m_ptr] = 1'b0;
        step();
        chk("full_after_xd0", 128'(outstanding), 128'(MO));

        // Random traffic with random response backpressure.
        resp_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NR; k++)
                if (!cvld[k] && $urandom_range(0, 2) == 0) new_cmd(k, 1'($urandom_range(0, 1)));
            acc_cmd_rdy = ($urandom_range(0, 3) != 0);
            drive_resp();
            step();
        end

        acc_cmd_rdy = 1'b1;
        guard = 0;
        while ((cvld != '0 || acc_todo.size() != 0) && guard < 300) begin
            drive_resp();
            step();
            guard++;
        end
        chk("drain_budget", 128'(guard < 300), 128'(1));
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));

        // Reset with two IDs outstanding, then rotation restarts at requester 0.
        resp_en = 1'b0;
        acc_resp_vld = 1'b0;
        new_cmd(0, 1'b1);
        step();
        new_cmd(1, 1'b1);
        step();
        chk("pre_reset_outstanding", 128'(outstanding), 128'(2));
        do_reset();
        new_cmd(0, 1'b1);
        new_cmd(1, 1'b1);
        acc_cmd_rdy = 1'b1;
        step();
        step();
        chk("post_reset_outstanding", 128'(outstanding), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rocc_arbiter.md
Name: rocc_arbiter

Overview:
- Shares one RoCC accelerator between NrReq command sources, e.g. the Ariane core plus a debug or DMA command injector.
- Grants commands round-robin to the single accelerator port.
- Records the granted requester ID for each command that expects a response.
- Routes in-order accelerator responses back to the originating requester.
- Sits between the core-side RoCC ports and the accelerator instance inside the tile wrapper.

Parameters:
- NrReq, 2: number of requesters; IdWidth = max(1, $clog2(NrReq)).
- CmdWidth, 128: flattened RoCC command width.
- RespWidth, 69: flattened RoCC response width.
- MaxOutstanding, 4: depth of the response-ID FIFO; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_cmd_i  in  NrReq*CmdWidth  per-requester command.
- req_cmd_xd_i  in  NrReq  1 = the command returns a response.
- req_cmd_valid_i  in  NrReq  command valid.
- req_cmd_ready_o  out  NrReq  command accepted.
- req_resp_o  out  RespWidth  response, broadcast to all requesters.
- req_resp_valid_o  out  NrReq  one-hot response valid.
- req_resp_ready_i  in  NrReq  requester can take the response.
- acc_cmd_o  out  CmdWidth  command to the accelerator.
- acc_cmd_valid_o  out  1  command valid.
- acc_cmd_ready_i  in  1  accelerator accepts.
- acc_resp_i  in  RespWidth  accelerator response.
- acc_resp_valid_i  in  1  response valid.
- acc_resp_ready_o  out  1  response accepted.
- outstanding_o  out  $clog2(MaxOutstanding)+1  FIFO occupancy.
- spurious_resp_o  out  1  sticky: response arrived while the FIFO was empty.
- grant_cnt_o  out  NrReq*32  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (async, rst_ni=0):
  - rr pointer=0, lock=0, FIFO empty, spurious_resp_o=0, counters=0.
  - All valid/ready outputs read 0; state clears immediately.
  - Reset mid-transaction discards queued IDs and pending grant.
- Arbitration:
  - Round-robin starting from the rr pointer over req_cmd_valid_i.
  - Zero-latency combinational path: acc_cmd_o = req_cmd_i[grant].
- Stall gating:
  - acc_cmd_valid_o = any_valid & ~(req_cmd_xd_i[grant] & fifo_full).
  - An xd=0 command is never blocked by a full FIFO.
- Lock:
  - If acc_cmd_valid_o=1 and acc_cmd_ready_i=0, register lock=1 and hold the grant index.
  - While locked, the grant stays fixed regardless of other valids.
  - Requesters must hold valid and data stable until accepted.
- Command handshake (acc_cmd_valid_o & acc_cmd_ready_i):
  - req_cmd_ready_o[grant]=1; all other ready bits 0.
  - rr pointer <= (grant+1) mod NrReq; lock <= 0.
  - If req_cmd_xd_i[grant], push grant onto the ID FIFO.
- Response path:
  - head = FIFO head ID.
  - req_resp_valid_o = onehot(head) & {NrReq{acc_resp_valid_i & ~empty}}.
  - acc_resp_ready_o = ~empty & req_resp_ready_i[head].
  - Pop on acc_resp_valid_i & acc_resp_ready_o.
- Full boundary: no push when full, even if a pop happens in the same cycle (deterministic, no bypass).
- Simultaneous push and pop when not full: occupancy unchanged; pointers both advance, wrapping mod MaxOutstanding.
- Empty boundary: if acc_resp_valid_i=1 while empty:
  - acc_resp_ready_o=0 (response held, not dropped).
  - spurious_resp_o <= 1 and stays set until reset.
- Responses are assumed in command order.
- outstanding_o is the registered occupancy, range 0..MaxOutstanding.

Optional Feature:
- Macro ROCC_ARB_PERF_CNT_EN.
- Defined: grant_cnt_o[k] holds a 32-bit counter per requester.
  - Increments on each accepted command from requester k.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0.
- Not defined: grant_cnt_o tied to '0; no counter flops synthesized.

Decomposition:
- Package rocc_arb_pkg holds:
  - IdWidth computation function.
  - Counter width constant (32).
  - Default CmdWidth/RespWidth constants matching the RoCC command/response structs.
- Natural sub-module rocc_arb_id_fifo: MaxOutstanding x IdWidth with push/pop/full/empty/usage.
- Round-robin selection stays inline.

Test Plan:
- Fairness: both requesters hold valid, accelerator always ready, all xd=1 -> grants alternate 0,1,0,1; FIFO IDs pushed in the same order.
- Backpressure lock: req0 valid, acc ready=0 for 3 cycles, req1 raises valid in cycle 1 -> acc_cmd_o stays req0's command; req0 accepted in cycle 3; req1 granted next.
- FIFO full: MaxOutstanding=4 with 4 xd=1 commands and no responses -> outstanding_o=4; a 5th xd=1 command sees acc_cmd_valid_o=0; a 5th xd=0 command is accepted.
- Response routing: issue IDs 1,0,1 -> three responses assert req_resp_valid_o = 2'b10, 2'b01, 2'b10; with req_resp_ready_i[1]=0, acc_resp_ready_o=0 until it rises.
- Spurious response: acc_resp_valid_i=1 with FIFO empty -> acc_resp_ready_o=0 and spurious_resp_o=1, sticky until rst_ni low.
- Reset mid-operation: 2 commands outstanding, drop rst_ni asynchronously -> outstanding_o=0, all valids 0, rr pointer 0; with ROCC_ARB_PERF_CNT_EN, counters read 0.
